// File: rtl/music_score_player.sv
// Score memory with a built-in sequencer: presents each stored (key, duration) entry
// for its length in beat ticks, with optional looping and host rewrites at any time.
module music_score_player #(
    parameter int KEY_BITS  = 4,
    parameter int TIME_BITS = 4,
    parameter int ADDR_BITS = 5,
    parameter int DEPTH     = 20
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 WriteEnable,
    input  logic [ADDR_BITS-1:0] WriteAddress,
    input  logic [KEY_BITS-1:0]  KeyIn,
    input  logic [TIME_BITS-1:0] TimeIn,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Loop,
    input  logic                 BeatTick,
    output logic [KEY_BITS-1:0]  Key,
    output logic                 Playing,
    output logic                 NoteStrobe,
    output logic                 Done,
    output logic [ADDR_BITS-1:0] Position
);

    // One extra bit so DEPTH == 2**ADDR_BITS still compares correctly.
    localparam logic [ADDR_BITS:0]   DEPTH_W  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST_POS = ADDR_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

    state_t               state;
    logic [TIME_BITS-1:0] remaining;
    logic [KEY_BITS-1:0]  key_mem  [0:DEPTH-1];
    logic [TIME_BITS-1:0] time_mem [0:DEPTH-1];
    logic [KEY_BITS-1:0]  fetch_key;
    logic [TIME_BITS-1:0] fetch_time;

    function automatic logic [KEY_BITS-1:0] default_key(input int idx);
        case (idx)
            0, 5, 6, 10: return KEY_BITS'(1);
            1, 4, 7, 9:  return KEY_BITS'(2);
            2, 3, 8:     return KEY_BITS'(3);
            default:     return '0;
        endcase
    endfunction

    function automatic logic [TIME_BITS-1:0] default_time(input int idx);
        if (idx == 0 || idx == 10) return TIME_BITS'(2);
        if (idx >= 1 && idx <= 9)  return TIME_BITS'(1);
        return '0;
    endfunction

    // Reset restores the default tune, overriding any host edits.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_mem[i]  <= default_key(i);
                time_mem[i] <= default_time(i);
            end
        end else if (WriteEnable && ({1'b0, WriteAddress} < DEPTH_W)) begin
            key_mem[WriteAddress]  <= KeyIn;
            time_mem[WriteAddress] <= TimeIn;
        end
    end

    // Asynchronous read sees pre-write contents on a same-cycle write.
    assign fetch_key  = key_mem[Position];
    assign fetch_time = time_mem[Position];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            remaining  <= '0;
            Key        <= '0;
            Playing    <= 1'b0;
            NoteStrobe <= 1'b0;
            Done       <= 1'b0;
            Position   <= '0;
        end else begin
            NoteStrobe <= 1'b0;
            if (Stop) begin
                state     <= IDLE;
                remaining <= '0;
                Key       <= '0;
                Playing   <= 1'b0;
                Done      <= 1'b0;
                Position  <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (Start) begin
                            Position <= '0;
                            Done     <= 1'b0;
                            Playing  <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (fetch_time != '0) begin
                            Key        <= fetch_key;
                            remaining  <= fetch_time;
                            NoteStrobe <= 1'b1;
                            state      <= PLAY;
                        end else if (Loop && Position != '0) begin
                            Position <= '0;
                        end else begin
                            Key     <= '0;
                            Done    <= 1'b1;
                            Playing <= 1'b0;
                            state   <= DONE;
                        end
                    end
                    PLAY: begin
                        if (BeatTick) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == TIME_BITS'(1)) begin
                                if (Position != LAST_POS) begin
                                    Position <= Position + 1'b1;
                                    state    <= FETCH;
                                end else if (Loop && Position != '0) begin
                                    Position <= '0;
                                    state    <= FETCH;
                                end else begin
                                    Key     <= '0;
                                    Done    <= 1'b1;
                                    Playing <= 1'b0;
                                    state   <= DONE;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_score_player.sv
// Bench for music_score_player: default-tune vector table, hand-written corner sequences,
// and random scores checked against a note-list model of the score.
module tb_music_score_player;
    localparam int KB    = 4;
    localparam int TB    = 4;
    localparam int AB    = 5;
    localparam int DEPTH = 20;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          WriteEnable = 1'b0;
    logic [AB-1:0] WriteAddress = '0;
    logic [KB-1:0] KeyIn = '0;
    logic [TB-1:0] TimeIn = '0;
    logic          Start = 1'b0, Stop = 1'b0, Loop = 1'b0, BeatTick = 1'b0;
    logic [KB-1:0] Key;
    logic          Playing, NoteStrobe, Done;
    logic [AB-1:0] Position;

    always #5 Clock = ~Clock;

    music_score_player #(.KEY_BITS(KB), .TIME_BITS(TB), .ADDR_BITS(AB), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
        .KeyIn(KeyIn), .TimeIn(TimeIn), .Start(Start), .Stop(Stop), .Loop(Loop),
        .BeatTick(BeatTick), .Key(Key), .Playing(Playing), .NoteStrobe(NoteStrobe),
        .Done(Done), .Position(Position)
    );

    typedef struct {int key; int pos; int ticks;} vec_t;
    vec_t tune_vec[11] = '{'{1, 0, 2}, '{2, 1, 1}, '{3, 2, 1}, '{3, 3, 1}, '{2, 4, 1}, '{1, 5, 1},
                           '{1, 6, 1}, '{2, 7, 1}, '{3, 8, 1}, '{2, 9, 1}, '{1, 10, 2}};

    int checks = 0, passed = 0;
    int m_key[DEPTH], m_time[DEPTH];
    int obs_key[$], obs_pos[$], obs_ticks[$];
    bit done_seen;
    int done_key, done_pos;
    int exp_key[$], exp_pos[$], exp_ticks[$];
    bit exp_done;
    int exp_done_pos;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic void load_default();
        int k[12] = '{1, 2, 3, 3, 2, 1, 1, 2, 3, 2, 1, 0};
        int t[12] = '{2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0};
        for (int i = 0; i < DEPTH; i++) begin
            m_key[i]  = (i < 12) ? k[i] : 0;
            m_time[i] = (i < 12) ? t[i] : 0;
        end
    endfunction

    // Walk the score as a musician would: list of notes played, then where it ended.
    function automatic void build_expected(input bit loop_m, input int cap);
        int pos = 0;
        exp_key.delete(); exp_pos.delete(); exp_ticks.delete();
        exp_done = 0; exp_done_pos = 0;
        for (int guard = 0; guard < 4 * cap + 4 * DEPTH && exp_key.size() < cap; guard++) begin
            if (m_time[pos] == 0) begin
                if (loop_m && pos != 0) pos = 0;
                else begin exp_done = 1; exp_done_pos = pos; break; end
            end else begin
                exp_key.push_back(m_key[pos]);
                exp_pos.push_back(pos);
                exp_ticks.push_back(m_time[pos]);
                if (pos == DEPTH - 1) begin
                    if (loop_m) pos = 0;
                    else begin exp_done = 1; exp_done_pos = pos; break; end
                end else pos++;
            end
        end
    endfunction

    task automatic wr(input int a, input int k, input int t);
        WriteEnable = 1'b1; WriteAddress = AB'(a); KeyIn = KB'(k); TimeIn = TB'(t);
        @(posedge Clock); @(negedge Clock);
        WriteEnable = 1'b0;
        if (a < DEPTH) begin m_key[a] = k; m_time[a] = t; end
    endtask

    task automatic stop_to_idle();
        Stop = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Stop = 1'b0;
        Loop = 1'b0;
    endtask

    // Start playback with a beat every 4 clocks and log each note with its tick count.
    task automatic run_play(input bit loop_m, input int cap);
        bit open = 0;
        int cur = 0;
        bit tick_now;
        obs_key.delete(); obs_pos.delete(); obs_ticks.delete();
        done_seen = 0; done_key = 0; done_pos = 0;
        Loop = loop_m; Start = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            BeatTick = (c % 4 == 3);
            tick_now = BeatTick && open;
            @(posedge Clock);
            if (tick_now) cur++;
            @(negedge Clock);
            Start = 1'b0;
            if (NoteStrobe) begin
                if (open) obs_ticks.push_back(cur);
                obs_key.push_back(Key); obs_pos.push_back(Position);
                open = 1; cur = 0;
            end
            if (Done) begin
                if (open) obs_ticks.push_back(cur);
                open = 0; done_seen = 1; done_key = Key; done_pos = Position;
                break;
            end
            if (obs_key.size() > cap) break;
            if (c == 3999) check("run_play cycle budget", 0, 1);
        end
        BeatTick = 1'b0;
    endtask

    task automatic compare_run(input string tag);
        int closed = obs_ticks.size();
        check({tag, " done"}, done_seen, exp_done);
        if (exp_done) begin
            check({tag, " note count"}, closed, exp_key.size());
            check({tag, " done position"}, done_pos, exp_done_pos);
            check({tag, " done key"}, done_key, 0);
        end else begin
            check({tag, " enough notes"}, closed >= exp_key.size(), 1);
        end
        for (int i = 0; i < exp_key.size() && i < closed; i++) begin
            check($sformatf("%s key[%0d]", tag, i), obs_key[i], exp_key[i]);
            check($sformatf("%s pos[%0d]", tag, i), obs_pos[i], exp_pos[i]);
            check($sformatf("%s ticks[%0d]", tag, i), obs_ticks[i], exp_ticks[i]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        load_default();
        repeat (2) @(negedge Clock);
        check("reset Key", Key, 0);
        check("reset Playing", Playing, 0);
        check("reset NoteStrobe", NoteStrobe, 0);
        check("reset Done", Done, 0);
        check("reset Position", Position, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Default tune against the vector table.
        run_play(0, 40);
        check("tune note count", obs_ticks.size(), 11);
        for (int i = 0; i < 11 && i < obs_ticks.size(); i++) begin
            check($sformatf("tune key[%0d]", i), obs_key[i], tune_vec[i].key);
            check($sformatf("tune pos[%0d]", i), obs_pos[i], tune_vec[i].pos);
            check($sformatf("tune ticks[%0d]", i), obs_ticks[i], tune_vec[i].ticks);
        end
        check("tune Done", Done, 1);
        check("tune end Key", Key, 0);
        check("tune end Position", Position, 11);
        check("tune end Playing", Playing, 0);
        stop_to_idle();
        check("stop clears Done", Done, 0);

        // Loop over three passes.
        build_expected(1, 33);
        run_play(1, 33);
        compare_run("loop");
        if (obs_key.size() > 11) begin
            check("loop wrap key", obs_key[11], 1);
            check("loop wrap pos", obs_pos[11], 0);
        end else check("loop wrap reached", obs_key.size(), 12);
        stop_to_idle();

        // Host edit plus an out-of-range write.
        wr(3, 7, 3);
        wr(25, 9, 9);
        build_expected(0, 40);
        run_play(0, 40);
        compare_run("edit");
        if (obs_ticks.size() > 3) begin
            check("edit 4th key", obs_key[3], 7);
            check("edit 4th ticks", obs_ticks[3], 3);
        end else check("edit 4th reached", obs_ticks.size(), 4);
        stop_to_idle();
        wr(3, 3, 1);

        // Stop mid-score, Start+Stop together, then a clean restart.
        found = 0; Loop = 1'b0; Start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            BeatTick = (c % 4 == 3);
            @(posedge Clock); @(negedge Clock);
            Start = 1'b0;
            if (NoteStrobe && Position == 5) begin found = 1; break; end
        end
        BeatTick = 1'b0;
        check("stop reached pos5", found, 1);
        Stop = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Stop = 1'b0;
        check("stop Playing", Playing, 0);
        check("stop Key", Key, 0);
        check("stop Position", Position, 0);
        Start = 1'b1; Stop = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Start = 1'b0; Stop = 1'b0;
        check("start+stop Playing", Playing, 0);
        Start = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Start = 1'b0;
        check("restart Playing", Playing, 1);
        check("restart no early strobe", NoteStrobe, 0);
        @(posedge Clock); @(negedge Clock);
        check("restart NoteStrobe", NoteStrobe, 1);
        check("restart Position", Position, 0);
        check("restart Key", Key, 1);
        stop_to_idle();

        // Empty score with Loop set ends instead of spinning.
        wr(0, 5, 0);
        Loop = 1'b1; Start = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Start = 1'b0;
        check("empty fetch Playing", Playing, 1);
        check("empty fetch Done", Done, 0);
        @(posedge Clock); @(negedge Clock);
        check("empty Done", Done, 1);
        check("empty Key", Key, 0);
        check("empty NoteStrobe", NoteStrobe, 0);
        check("empty Playing", Playing, 0);
        stop_to_idle();
        wr(0, 1, 2);

        // Reset mid-note restores the default tune.
        wr(3, 9, 2);
        found = 0; Start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            BeatTick = (c % 4 == 3);
            @(posedge Clock); @(negedge Clock);
            Start = 1'b0;
            if (NoteStrobe && Position == 3) begin found = 1; break; end
        end
        BeatTick = 1'b0;
        check("reset test reached pos3", found, 1);
        check("edited key before reset", Key, 9);
        #2 Reset = 1'b1;
        #1;
        check("async reset Key", Key, 0);
        check("async reset Playing", Playing, 0);
        check("async reset NoteStrobe", NoteStrobe, 0);
        check("async reset Position", Position, 0);
        load_default();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        build_expected(0, 40);
        run_play(0, 40);
        compare_run("after reset");
        if (obs_ticks.size() > 3) begin
            check("restored key3", obs_key[3], 3);
            check("restored ticks3", obs_ticks[3], 1);
        end else check("restored key3 reached", obs_ticks.size(), 4);
        stop_to_idle();

        // Random scores, random end marker, random Loop.
        for (int it = 0; it < 6; it++) begin
            int e;
            bit lp;
            for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 15), $urandom_range(1, 3));
            e = $urandom_range(0, DEPTH);
            if (e < DEPTH) wr(e, $urandom_range(0, 15), 0);
            wr($urandom_range(DEPTH, 31), $urandom_range(0, 15), $urandom_range(0, 15));
            lp = 1'($urandom_range(0, 1));
            build_expected(lp, lp ? 25 : 40);
            run_play(lp, lp ? 25 : 40);
            compare_run($sformatf("random%0d", it));
            stop_to_idle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
